// File: rtl/hera_lsu_pkg.sv
// hera_lsu_pkg: shared types and defaults for the HERA load/store unit.
// Holds the FSM state encoding, timeout/error defaults and the address helper.
package hera_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DELIVER = 2'd3
  } lsu_state_e;

  localparam int unsigned TIMEOUT_DEF  = 15;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  // Effective word address; wraps modulo 2^16.
  function automatic logic [15:0] lsu_ea(
    input logic [15:0] base,
    input logic [4:0]  off
  );
    return base + {11'b0, off};
  endfunction

endpackage

// File: rtl/hera_lsu.sv
// hera_lsu: load/store unit; runs req/ack data-memory transactions for
// LOAD/STORE, stalls decode while busy and delivers load data to the regfile.
// Ports: clk/rst_s; decode side load_req, store_req, base, offset, rd,
// store_data, stall; regfile side load_en, ld_rd, load; memory side mem_req,
// mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack; sticky lsu_err.
module hera_lsu
  import hera_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_s,
  input  logic        load_req,
  input  logic        store_req,
  input  logic [15:0] base,
  input  logic [4:0]  offset,
  input  logic [3:0]  rd,
  input  logic [15:0] store_data,
  output logic        stall,
  output logic        load_en,
  output logic [3:0]  ld_rd,
  output logic [15:0] load,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        lsu_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  rd_q, rd_d;
  logic [15:0] data_q, data_d;
  logic [15:0] load_q, load_d;
  logic [3:0]  ldrd_q, ldrd_d;
  logic        err_q, err_d;
  logic        tmo;

  // Timeout fires in the wait cycle after TIMEOUT ack-less cycles.
  assign tmo = (cnt_q == TMO) && !mem_ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    data_d  = data_q;
    load_d  = load_q;
    ldrd_d  = ldrd_q;
    err_d   = err_q;
    stall   = 1'b0;
    load_en = 1'b0;
    ld_rd   = ldrd_q;
    unique case (state_q)
      IDLE: begin
        if (mem_ack) err_d = 1'b1;
        if (load_req) begin
          // A colliding store is dropped and flagged.
          if (store_req) err_d = 1'b1;
          addr_d  = lsu_ea(base, offset);
          rd_d    = rd;
          req_d   = 1'b1;
          we_d    = 1'b0;
          stall   = 1'b1;
          state_d = RD_WAIT;
        end else if (store_req) begin
          addr_d  = lsu_ea(base, offset);
          wdata_d = store_data;
          req_d   = 1'b1;
          we_d    = 1'b1;
          stall   = 1'b1;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = DELIVER;
        end else if (tmo) begin
          data_d  = ERR_DATA;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_WAIT: begin
        // Decode may proceed in the cycle the write completes.
        stall = !(mem_ack || tmo);
        if (mem_ack) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (tmo) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DELIVER: begin
        if (mem_ack) err_d = 1'b1;
        load_en = 1'b1;
        ld_rd   = rd_q;
        ldrd_d  = rd_q;
        load_d  = data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rd_q    <= 4'd0;
      data_q  <= 16'd0;
      load_q  <= 16'd0;
      ldrd_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ldrd_q  <= ldrd_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load      = load_q;
  assign lsu_err   = err_q;

endmodule

// File: tb/tb_hera_lsu.sv
// tb_hera_lsu: scoreboard bench for hera_lsu.
// Directed loads/stores; a memory responder and load monitor check the queues.
module tb_hera_lsu;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_s;
  logic        load_req, store_req;
  logic [15:0] base;
  logic [4:0]  offset;
  logic [3:0]  rd;
  logic [15:0] store_data;
  logic        stall, load_en;
  logic [3:0]  ld_rd;
  logic [15:0] load;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        lsu_err;

  hera_lsu #(.TIMEOUT(TMO), .ERR_DATA(16'hDEAD)) dut (
    .clk(clk), .rst_s(rst_s),
    .load_req(load_req), .store_req(store_req),
    .base(base), .offset(offset), .rd(rd),
    .store_data(store_data), .stall(stall),
    .load_en(load_en), .ld_rd(ld_rd), .load(load),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } mexp_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } lexp_t;

  mexp_t mq[$];
  lexp_t lq[$];
  mexp_t cur;
  lexp_t lcur;

  int          ack_dly   = 0;
  logic        no_ack    = 1'b0;
  logic        force_ack = 1'b0;
  logic [15:0] rdv       = 16'h0;
  logic        busy      = 1'b0;
  int          wc        = 0;
  logic        lpend     = 1'b0;

  // Memory responder + request monitor.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wc   = 0;
          if (mq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mem_unexp: got req addr %0h want none", mem_addr);
          end else begin
            cur = mq.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", mem_we, cur.we);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end else begin
          wc++;
          chk("mem_hold",
              {mem_we, mem_addr, cur.we ? mem_wdata : 16'h0},
              {cur.we, cur.addr, cur.we ? cur.wdata : 16'h0});
        end
        mem_ack   = force_ack | (!no_ack && wc == ack_dly);
        mem_rdata = rdv;
      end else begin
        busy    = 1'b0;
        mem_ack = force_ack;
      end
    end
  end

  // Load delivery monitor.
  initial forever begin
    @(negedge clk);
    if (lpend) begin
      chk("load", load, lcur.data);
      lpend = 1'b0;
    end
    if (load_en) begin
      if (lq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_en_unexp: got rd %0h want no load_en", ld_rd);
      end else begin
        lcur = lq.pop_front();
        chk("ld_rd", ld_rd, lcur.rd);
        lpend = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic do_load(
    input logic [15:0] b, input logic [4:0] o, input logic [3:0] r,
    input int dly, input logic na, input logic both,
    input logic [15:0] rdat, input logic [15:0] ea,
    input logic [15:0] ed
  );
    mexp_t me;
    lexp_t le;
    int cyc, reqc, sbad, lat;
    me.addr = ea; me.we = 1'b0; me.wdata = 16'h0;
    le.rd = r; le.data = ed;
    mq.push_back(me);
    lq.push_back(le);
    ack_dly = dly; no_ack = na; rdv = rdat;
    lat = na ? TMO + 2 : dly + 2;
    @(negedge clk);
    base = b; offset = o; rd = r; load_req = 1'b1;
    store_req = both; store_data = 16'h7777;
    #1 chk("req_stall", stall, 1);
    @(negedge clk);
    load_req = 1'b0; store_req = 1'b0;
    cyc = 1; reqc = 0; sbad = 0;
    while (!load_en && cyc < 100) begin
      if (mem_req) reqc++;
      if (!stall) sbad++;
      @(negedge clk);
      cyc++;
    end
    chk("ld_latency", cyc, lat);
    chk("ld_req_cycles", reqc, lat - 1);
    chk("ld_stall_wait", sbad, 0);
    chk("ld_stall_deliver", stall, 0);
    @(negedge clk);
    no_ack = 1'b0;
  endtask

  task automatic do_store(
    input logic [15:0] b, input logic [4:0] o, input logic [15:0] d,
    input int dly, input logic [15:0] ea
  );
    mexp_t me;
    int cyc, reqc;
    me.addr = ea; me.we = 1'b1; me.wdata = d;
    mq.push_back(me);
    ack_dly = dly;
    @(negedge clk);
    base = b; offset = o; store_data = d; store_req = 1'b1;
    #1 chk("st_req_stall", stall, 1);
    @(negedge clk);
    store_req = 1'b0;
    cyc = 1; reqc = 0;
    while (stall && cyc < 100) begin
      if (mem_req) reqc++;
      @(negedge clk);
      cyc++;
    end
    chk("st_stall_release", cyc, dly + 1);
    chk("st_wait_cycles", reqc, dly);
    chk("st_req_ack_cycle", mem_req, 1);
    @(negedge clk);
    chk("st_req_drop", mem_req, 0);
  endtask

  initial begin
    rst_s = 1'b1;
    load_req = 1'b0; store_req = 1'b0;
    base = 16'h0; offset = 5'h0; rd = 4'h0; store_data = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_load", load, 0);
    chk("rst_ld_rd", ld_rd, 0);
    rst_s = 1'b0;

    do_load(16'h1000, 5'd5, 4'd3, 0, 1'b0, 1'b0, 16'hBEEF, 16'h1005, 16'hBEEF);
    chk("err_after_load", lsu_err, 0);
    do_store(16'h0020, 5'd0, 16'h1234, 3, 16'h0020);
    chk("err_after_store", lsu_err, 0);
    chk("load_held", load, 16'hBEEF);
    do_load(16'hFFFE, 5'd3, 4'd7, 1, 1'b0, 1'b0, 16'h5A5A, 16'h0001, 16'h5A5A);
    do_store(16'hFFFF, 5'd1, 16'hCAFE, 0, 16'h0000);
    chk("err_after_wrap", lsu_err, 0);
    chk("ld_rd_held", ld_rd, 7);

    do_load(16'h0040, 5'd2, 4'd5, 0, 1'b0, 1'b1, 16'h0BAD, 16'h0042, 16'h0BAD);
    chk("err_both_req", lsu_err, 1);

    do_reset();
    chk("err_cleared", lsu_err, 0);
    do_load(16'h0100, 5'd31, 4'd9, 0, 1'b1, 1'b0, 16'h1111, 16'h011F, 16'hDEAD);
    chk("err_timeout", lsu_err, 1);
    repeat (3) @(negedge clk);
    chk("tmo_load_held", load, 16'hDEAD);
    chk("tmo_ld_rd_held", ld_rd, 9);

    do_reset();
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_idle_ack", lsu_err, 1);

    do_reset();
    begin
      mexp_t me;
      me.addr = 16'h2003; me.we = 1'b0; me.wdata = 16'h0;
      mq.push_back(me);
    end
    no_ack = 1'b1;
    @(negedge clk);
    base = 16'h2000; offset = 5'd3; rd = 4'd4; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    chk("mid_req_before", mem_req, 1);
    rst_s = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall, 0);
    @(negedge clk);
    rst_s = 1'b0;
    no_ack = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_ld_rd", ld_rd, 0);
    chk("mid_rst_err", lsu_err, 0);

    chk("mq_empty", mq.size(), 0);
    chk("lq_empty", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
